seg_scan_driver: RTL

// - Time-multiplexed driver for DIGITS common-anode 7-segment digits sharing one segment bus.
// - Hex font, per-digit decimal point and per-digit blink; tear-free frame-synchronous update.
// - Sits between the FSM/datapath that produces the numbers and the board's seg/an pins.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_font.sv | 17 +
 rtl/seg_scan_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low {a..g,dp} font, blank code and digit-index width helper.
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Segment order {a,b,c,d,e,f,g,dp}, 0 = lit; dp bit left dark (1) in every entry.
  localparam seg_t SEG_FONT [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  function automatic int seg_digit_w(input int digits);
    return (digits < 2) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Hex nibble to active-low segment pattern; blank darkens a..g but keeps the decimal point.
// Purely combinational, no flow control.
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg    = blank ? SEG_BLANK : SEG_FONT[nibble];
    seg[0] = ~dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous update and blink.
// Outputs registered, 1 cycle after digit_idx; no backpressure, load is a fire-and-forget strobe.
// Optional `SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output seg_t                  seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = seg_digit_w(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRESC_TC   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_TC   = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]            presc;
  logic [IW-1:0]            digit_idx;
  logic [BW-1:0]            blink_cnt;
  logic                     blink_ph;
  logic                     pending;
  logic [DIGITS-1:0][3:0]   num_sh, num_act;
  logic [DIGITS-1:0]        dp_sh, dp_act;
  logic [DIGITS-1:0]        bl_sh, bl_act;
  logic [DIGITS-1:0]        lzb_mask;

  logic tc, wrap;
  seg_t font_seg, glyph;

  assign tc         = (presc == PRESC_TC);
  assign wrap       = tc && (digit_idx == LAST_DIGIT);
  assign frame_done = wrap;

`ifdef SEG_LZB_EN
  // Digit i is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lzb_mask   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (num_act[i] == 4'd0);
      lzb_mask[i] = zero_above;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  seg_hex_font u_font (
    .nibble (num_act[digit_idx]),
    .dp     (dp_act[digit_idx]),
    .blank  (lzb_mask[digit_idx]),
    .seg    (font_seg)
  );

  assign glyph = (blink_ph && bl_act[digit_idx]) ? SEG_BLANK : font_seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      digit_idx <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      pending   <= 1'b0;
      num_sh    <= '0;
      num_act   <= '0;
      dp_sh     <= '0;
      dp_act    <= '0;
      bl_sh     <= '0;
      bl_act    <= '0;
      seg       <= SEG_BLANK;
      an        <= '1;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc)
        digit_idx <= (digit_idx == LAST_DIGIT) ? '0 : digit_idx + 1'b1;

      if (wrap) begin
        if (blink_cnt == BLINK_TC) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // A load landing on the wrap bypasses the shadow so it is not held back a whole frame.
      if (load) begin
        num_sh <= num;
        dp_sh  <= dp_mask;
        bl_sh  <= blink_mask;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (load) begin
          num_act <= num;
          dp_act  <= dp_mask;
          bl_act  <= blink_mask;
        end else if (pending) begin
          num_act <= num_sh;
          dp_act  <= dp_sh;
          bl_act  <= bl_sh;
        end
      end else if (load) begin
        pending <= 1'b1;
      end

      // The slot right after a digit change is dark so the previous glyph cannot ghost.
      if (!en || tc) begin
        seg <= SEG_BLANK;
        an  <= '1;
      end else begin
        seg <= glyph;
        an  <= ~(DIGITS'(1) << digit_idx);
      end
    end
  end

endmodule
